sig_capture: RTL
================

Name: sig_capture

Overview:
- Triggered capture-and-readout buffer for the mic sample stream. It is the reader-side complement of the continuous delay line.
- Writes samples into an internal circular RAM and keeps a programmable number of pre-trigger samples.
- Stops writing once the buffer is full after a rising threshold crossing.
- Streams the captured window out, oldest sample first, over a valid/ready handshake to the display/Vbuddy plotting path.

Parameters:
ADDRESS_WIDTH, 9, RAM address width; DEPTH = 2**ADDRESS_WIDTH samples captured per shot
DATA_WIDTH, 8, sample width (unsigned)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
arm  input  1  start a capture; accepted only in IDLE
abort  input  1  return to IDLE from any state; takes priority over everything except rst
sample_en  input  1  one-cycle strobe qualifying mic_signal
mic_signal  input  DATA_WIDTH  input sample
threshold  input  DATA_WIDTH  trigger level, live (not latched)
pre_count  input  ADDRESS_WIDTH  pre-trigger samples to keep; latched on accepted arm
out_ready  input  1  downstream accepts out_data
out_valid  output  1  out_data holds a captured sample
out_data  output  DATA_WIDTH  captured sample
busy  output  1  high in any state other than IDLE
triggered  output  1  high from the trigger sample until return to IDLE
done  output  1  one-cycle pulse after the last sample is handed off

Behaviour:
- Reset (rst low, async): state IDLE; wp, rd counters, pre_latched = 0; prev = all-ones; all outputs 0. RAM contents are undefined.
- States: IDLE, PRETRIG, ARMED, POST, DRAIN.
- IDLE, on arm:
  - latch pre_count; set wp = 0; set prev = all-ones.
  - go to PRETRIG if pre_count != 0, otherwise ARMED.
- PRETRIG: each sample_en writes RAM[wp], wp++, prev <= mic_signal. After pre_latched writes, go to ARMED. No trigger detection in this state.
- ARMED:
  - each sample_en writes RAM[wp], wp++ (mod DEPTH), prev <= mic_signal.
  - trigger when prev < threshold && mic_signal >= threshold. Unsigned compare.
  - the trigger sample itself is written. Record trig_addr = wp before increment. Set triggered, load post_left = DEPTH - pre_latched - 1, go to POST (or directly to DRAIN if post_left == 0).
  - prev = all-ones after arm guarantees the first sample cannot trigger.
- POST: each sample_en writes RAM[wp], wp++, post_left--. When post_left reaches 0 on a write, go to DRAIN.
- sample_en in IDLE or DRAIN: no write, no state change.
- DRAIN:
  - rd starts at trig_addr - pre_latched (mod DEPTH). Read DEPTH samples in address order, wrapping.
  - RAM is synchronous read, 1-cycle latency. out_valid rises no later than 2 cycles after entering DRAIN.
  - a handshake is out_valid && out_ready.
  - while out_valid && !out_ready, out_data and out_valid hold stable.
  - with out_ready held high, one sample per cycle after the first.
  - after the DEPTH-th handshake: out_valid drops next cycle, done pulses 1 cycle, go to IDLE, triggered clears.
- arm outside IDLE is ignored. arm and abort in the same cycle in IDLE: abort wins, stay IDLE.
- abort: next cycle state IDLE; out_valid, triggered, busy = 0; no done pulse. Partial data is discarded.
- Captured window is exactly pre_latched samples before the trigger sample, the trigger sample, then DEPTH - pre_latched - 1 samples after it.
- Samples older than the window have been overwritten by ARMED wrap-around and are never emitted.
- threshold change mid-capture takes effect on the next sample_en.

Test Plan:
- Bench uses ADDRESS_WIDTH=4 (DEPTH=16).
- Basic: pre_count=4, threshold=0x80, ramp 0x00,0x10,…; out_ready=1 -> trigger on 0x80. Out stream 0x40,0x50,…,0x70,0x80,…, 16 values total. done pulses once; busy low after.
- Backpressure: same capture, out_ready toggles 1/0 per cycle -> 16 unique values in order, none lost or duplicated, out_data stable during every stall.
- pre_count=0 with sample 0x90 first -> no trigger on the first sample even if ≥ threshold. Pattern 0x10,0x90 triggers on 0x90, which is emitted first.
- Long ARMED wrap: pre_count=15, 40 sub-threshold samples, then crossing -> output is the 15 samples immediately before the trigger plus the trigger sample. The earliest 25 samples are absent.
- Abort in POST, then in DRAIN after 5 handshakes -> IDLE next cycle, out_valid=0, no done. A following arm captures normally.
- Async reset asserted mid-DRAIN without a clock edge -> out_valid, busy, triggered, done = 0 immediately. arm during reset is ignored.

Source files
------------

// File: rtl/sig_capture.sv
// Triggered capture-and-readout buffer for the mic sample stream.
// Samples are written into a circular RAM. A programmable number of
// pre-trigger samples is kept, and writing stops once the buffer holds a full
// window around a rising threshold crossing. The window is then streamed out,
// oldest sample first, over a valid/ready handshake.
module sig_capture #(
   parameter int ADDRESS_WIDTH = 9,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     arm,
   input  logic                     abort,
   input  logic                     sample_en,
   input  logic [DATA_WIDTH-1:0]    mic_signal,
   input  logic [DATA_WIDTH-1:0]    threshold,
   input  logic [ADDRESS_WIDTH-1:0] pre_count,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     busy,
   output logic                     triggered,
   output logic                     done
);

   localparam int DEPTH = 2 ** ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);
   localparam logic [ADDRESS_WIDTH:0]   CNT_ONE  = (ADDRESS_WIDTH+1)'(1);
   localparam logic [ADDRESS_WIDTH:0]   CNT_FULL = (ADDRESS_WIDTH+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRETRIG,
      S_ARMED,
      S_POST,
      S_DRAIN
   } state_t;

   state_t state, state_next;

   logic [DATA_WIDTH-1:0]    mem [DEPTH];
   logic [ADDRESS_WIDTH-1:0] wp;           // next write address
   logic [ADDRESS_WIDTH-1:0] rd;           // next read address during DRAIN
   logic [ADDRESS_WIDTH-1:0] trig_addr;    // RAM address of the trigger sample
   logic [ADDRESS_WIDTH-1:0] pre_latched;  // pre-trigger length for this shot
   logic [ADDRESS_WIDTH-1:0] post_left;    // post-trigger writes still owed
   logic [ADDRESS_WIDTH:0]   rd_cnt;       // RAM reads issued in this DRAIN
   logic [DATA_WIDTH-1:0]    prev;         // previous sample, for edge detection

   logic                     capturing;
   logic                     we;
   logic                     trig_hit;
   logic                     pre_last;
   logic                     post_last;
   logic                     handshake;
   logic                     rd_en;
   logic                     drain_last;
   logic [ADDRESS_WIDTH-1:0] post_init;

   // DEPTH - pre - 1 is simply the bitwise complement within ADDRESS_WIDTH bits.
   assign post_init  = {ADDRESS_WIDTH{1'b1}} - pre_latched;

   assign capturing  = (state == S_PRETRIG) || (state == S_ARMED) || (state == S_POST);
   assign we         = capturing && sample_en && !abort;
   assign trig_hit   = (state == S_ARMED) && sample_en &&
                       (prev < threshold) && (mic_signal >= threshold);
   assign pre_last   = (state == S_PRETRIG) && sample_en && ((wp + ADDR_ONE) == pre_latched);
   assign post_last  = (state == S_POST) && sample_en && (post_left == ADDR_ONE);
   assign handshake  = out_valid && out_ready;
   // A new read is issued only when the output register is empty or being
   // consumed this cycle, so out_data never changes under a stalled handshake.
   assign rd_en      = (state == S_DRAIN) && !abort && (rd_cnt != CNT_FULL) &&
                       (!out_valid || out_ready);
   assign drain_last = (state == S_DRAIN) && handshake && (rd_cnt == CNT_FULL);

   assign busy       = (state != S_IDLE);

   // State register.
   // NOTE: every clocked block uses non-blocking assignments so all registers
   // update together from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   // Next-state decode; abort overrides every transition.
   // NOTE: state_next gets its default before the case so no latch is inferred.
   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = S_IDLE;
      end else begin
         case (state)
            S_IDLE:    if (arm)        state_next = (pre_count != '0) ? S_PRETRIG : S_ARMED;
            S_PRETRIG: if (pre_last)   state_next = S_ARMED;
            S_ARMED:   if (trig_hit)   state_next = (post_init == '0) ? S_DRAIN : S_POST;
            S_POST:    if (post_last)  state_next = S_DRAIN;
            S_DRAIN:   if (drain_last) state_next = S_IDLE;
            default:                   state_next = S_IDLE;
         endcase
      end
   end

   // Sample RAM write port.
   // NOTE: the RAM array has no reset so it maps onto block RAM; a location is
   // only read back after it has been written in the current capture.
   always_ff @(posedge clk) begin
      if (we) mem[wp] <= mic_signal;
   end

   // Capture pointers, trigger bookkeeping and the registered read port.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp          <= '0;
         rd          <= '0;
         trig_addr   <= '0;
         pre_latched <= '0;
         post_left   <= '0;
         rd_cnt      <= '0;
         prev        <= '1;
         out_valid   <= 1'b0;
         out_data    <= '0;
         triggered   <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            out_valid <= 1'b0;
            triggered <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (arm) begin
                     pre_latched <= pre_count;
                     wp          <= '0;
                     prev        <= '1;   // first sample after arm can never be a crossing
                     rd_cnt      <= '0;
                  end
               end
               S_PRETRIG, S_ARMED, S_POST: begin
                  if (sample_en) begin
                     wp   <= wp + ADDR_ONE;
                     prev <= mic_signal;
                  end
                  if (state == S_POST && sample_en) post_left <= post_left - ADDR_ONE;
                  if (trig_hit) begin
                     trig_addr <= wp;
                     triggered <= 1'b1;
                     post_left <= post_init;
                     // Used directly when no post-trigger samples are owed.
                     rd        <= wp - pre_latched;
                  end
                  if (post_last) rd <= trig_addr - pre_latched;
               end
               S_DRAIN: begin
                  if (rd_en) begin
                     out_data  <= mem[rd];
                     out_valid <= 1'b1;
                     rd        <= rd + ADDR_ONE;
                     rd_cnt    <= rd_cnt + CNT_ONE;
                  end else if (handshake) begin
                     out_valid <= 1'b0;
                  end
                  if (drain_last) begin
                     done      <= 1'b1;
                     triggered <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
